// File: rtl/video_scanout.sv
// Raster scanout: pops RGB565 words from a FIFO and drives hsync/vsync/de/rgb.
// Define VIDOUT_PIXEL_DOUBLE_EN to show each FIFO word on two adjacent pixels.
module video_scanout #(
  parameter int          H_ACTIVE       = 640,
  parameter int          H_FP           = 16,
  parameter int          H_SYNC         = 96,
  parameter int          H_BP           = 48,
  parameter int          V_ACTIVE       = 480,
  parameter int          V_FP           = 10,
  parameter int          V_SYNC         = 2,
  parameter int          V_BP           = 33,
  parameter logic        SYNC_POL       = 1'b0,
  parameter logic [15:0] UNDERRUN_COLOR = 16'hF81F
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        enable,
  output logic        read,
  input  logic [15:0] read_data,
  input  logic        can_read,
  input  logic        underrun_clear,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic        frame_start,
  output logic        underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [31:0] H_ACT = 32'(H_ACTIVE);
  localparam logic [31:0] H_SS  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SE  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] H_END = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_ACT = 32'(V_ACTIVE);
  localparam logic [31:0] V_SS  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SE  = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] V_END = 32'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  logic [HW-1:0] h_cnt, h_nx;
  logic [VW-1:0] v_cnt, v_nx;
  logic [31:0]   h_ext, v_ext;

  logic        go, active, pop_slot, starve;
  logic        h_sync_on, v_sync_on;
  logic [15:0] pix;

  logic        hsync_nx, vsync_nx, de_nx, fs_nx, und_nx;
  logic [15:0] rgb_nx;

`ifdef VIDOUT_PIXEL_DOUBLE_EN
  logic [15:0] hold, hold_nx;
`endif

  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  always_comb begin
    go        = (state == RUN) && enable && !reset;
    active    = (h_ext < H_ACT) && (v_ext < V_ACT);
    h_sync_on = (h_ext >= H_SS) && (h_ext < H_SE);
    v_sync_on = (v_ext >= V_SS) && (v_ext < V_SE);

`ifdef VIDOUT_PIXEL_DOUBLE_EN
    pop_slot = !h_cnt[0];
`else
    pop_slot = 1'b1;
`endif

    read   = go && active && pop_slot && can_read;
    starve = go && active && pop_slot && !can_read;

    pix = can_read ? read_data : UNDERRUN_COLOR;
`ifdef VIDOUT_PIXEL_DOUBLE_EN
    // Odd pixels replay whatever the even pixel showed, underrun colour included.
    if (!pop_slot) pix = hold;
    hold_nx = (go && active && pop_slot) ? pix : hold;
`endif
  end

  always_comb begin
    state_nx = enable ? RUN : IDLE;
    h_nx     = '0;
    v_nx     = '0;
    if (go) begin
      if (h_ext == H_END) begin
        v_nx = (v_ext == V_END) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nx = h_cnt + 1'b1;
        v_nx = v_cnt;
      end
    end

    de_nx    = go && active;
    rgb_nx   = de_nx ? pix : 16'h0000;
    hsync_nx = (go && h_sync_on) ? SYNC_POL : !SYNC_POL;
    vsync_nx = (go && v_sync_on) ? SYNC_POL : !SYNC_POL;
    fs_nx    = go && (h_cnt == '0) && (v_cnt == '0);
    und_nx   = underrun;
    if (starve) und_nx = 1'b1;
    else if (underrun_clear) und_nx = 1'b0;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      de          <= 1'b0;
      rgb         <= 16'h0000;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nx;
      h_cnt       <= h_nx;
      v_cnt       <= v_nx;
      hsync       <= hsync_nx;
      vsync       <= vsync_nx;
      de          <= de_nx;
      rgb         <= rgb_nx;
      frame_start <= fs_nx;
      underrun    <= und_nx;
    end
  end

`ifdef VIDOUT_PIXEL_DOUBLE_EN
  always_ff @(posedge pixel_clk) begin
    if (reset) hold <= 16'h0000;
    else       hold <= hold_nx;
  end
`endif

endmodule

// File: tb/tb_video_scanout.sv
// Scoreboarded random/directed bench for video_scanout on a tiny 8x5 raster.
// A frame-position model predicts read each cycle and the registered outputs.
module tb_video_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [15:0] UC = 16'hF81F;

  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        can_read = 1'b0;
  logic        underrun_clear = 1'b0;
  logic [15:0] read_data = 16'h0000;
  logic        read, hsync, vsync, de, frame_start, underrun;
  logic [15:0] rgb;

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .UNDERRUN_COLOR(UC)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .enable(enable),
    .read(read),
    .read_data(read_data),
    .can_read(can_read),
    .underrun_clear(underrun_clear),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start),
    .underrun(underrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
    logic        fs;
    logic        ur;
  } obs_t;

  obs_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  bit          m_run = 1'b0;
  int          m_pos = 0;
  bit          m_ur = 1'b0;
  logic [15:0] m_held = 16'h0000;
  logic [15:0] src[$];
  logic [15:0] next_word = 16'h0001;

  task automatic step(input bit rst, input bit en, input bit cr, input bit clr);
    obs_t e;
    bit   exp_read, set, act, slot;
    int   h, v;
    logic [15:0] px;
    @(negedge pixel_clk);
    if (src.size() == 0) begin
      src.push_back(next_word);
      next_word = next_word + 16'h0001;
    end
    reset          = rst;
    enable         = en;
    can_read       = cr;
    underrun_clear = clr;
    read_data      = cr ? src[0] : 16'($urandom);
    #1;
    exp_read = 1'b0;
    set      = 1'b0;
    e        = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 16'h0000, fs: 1'b0, ur: m_ur};
    if (rst) begin
      m_run = 1'b0;
      m_pos = 0;
      m_ur  = 1'b0;
    end else begin
      if (m_run && en) begin
        h   = m_pos % HT;
        v   = m_pos / HT;
        act = (h < HA) && (v < VA);
`ifdef VIDOUT_PIXEL_DOUBLE_EN
        slot = (h % 2) == 0;
`else
        slot = 1'b1;
`endif
        if (act) begin
          if (slot) begin
            px       = cr ? src[0] : UC;
            set      = !cr;
            exp_read = cr;
            m_held   = px;
          end else begin
            px = m_held;
          end
          e.de  = 1'b1;
          e.rgb = px;
        end
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.fs  = (m_pos == 0);
        m_pos = (m_pos + 1) % (HT * VT);
      end else begin
        m_pos = 0;
      end
      m_run = en;
      if (set) m_ur = 1'b1;
      else if (clr) m_ur = 1'b0;
    end
    e.ur = m_ur;
    compared++;
    if (read !== exp_read) begin
      mismatched++;
      $display("FAIL read pos=%0d got=%b want=%b", m_pos, read, exp_read);
    end
    if (exp_read) void'(src.pop_front());
    exp_q.push_back(e);
  endtask

  initial begin
    obs_t e, got;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{hs: hsync, vs: vsync, de: de, rgb: rgb, fs: frame_start, ur: underrun};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL outputs hs/vs/de/rgb/fs/ur got=%b/%b/%b/%h/%b/%b want=%b/%b/%b/%h/%b/%b",
                   got.hs, got.vs, got.de, got.rgb, got.fs, got.ur,
                   e.hs, e.vs, e.de, e.rgb, e.fs, e.ur);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);

    src.delete();
`ifdef VIDOUT_PIXEL_DOUBLE_EN
    src.push_back(16'hdead);
    src.push_back(16'hbeef);
    src.push_back(16'hfeed);
    src.push_back(16'hface);
`endif
    repeat (82) step(1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, m_pos != 2, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, m_pos != 1, m_pos == 1);

    for (int i = 0; i < 50 && m_pos != 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (45) step(1'b0, 1'b1, 1'b1, 1'b0);

    repeat (400) step(1'b0, $urandom_range(0, 49) != 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, m_pos != 3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (45) step(1'b0, 1'b1, 1'b1, 1'b0);

    repeat (2) @(posedge pixel_clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
